// File: rtl/fpga_ack_handshake_ctrl_if.sv
// Avalon-MM register port plus the req/ack pair to the fabric peer.
// master: host/peer side that drives the bus; slave: the controller.
interface fpga_ack_handshake_ctrl_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        ack_in;
  logic        req_out;
  logic        irq;

  modport master (
    output address, chipselect, write, writedata, ack_in,
    input  readdata, req_out, irq
  );

  modport slave (
    input  address, chipselect, write, writedata, ack_in,
    output readdata, req_out, irq
  );
endinterface

// File: rtl/fpga_ack_handshake_ctrl.sv
// Four-phase req/ack handshake controller behind a 4-word Avalon-MM register map.
// Read latency 1 cycle, writes take effect on the next edge; no bus backpressure.
module fpga_ack_handshake_ctrl #(
  parameter logic [15:0] TIMEOUT_RST = 16'hFFFF,
  parameter int          SYNC_STAGES = 2
) (
  input logic                        clk,
  input logic                        reset,
  fpga_ack_handshake_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_REL  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t                 r_state;
  logic                   r_req_out;
  logic [15:0]            r_count;
  logic [15:0]            r_cycles;
  logic [15:0]            r_tmo_val;
  logic                   r_irq_en;
  logic                   r_done;
  logic                   r_tmo_flag;
  logic                   r_stuck;
  logic                   r_irq;
  logic [31:0]            r_rdata;
  logic [SYNC_STAGES-1:0] r_sync;

  logic        w_wr;
  logic        w_ctrl_wr;
  logic        w_stat_wr;
  logic        w_tmo_wr;
  logic        w_start;
  logic        w_abort;
  logic        w_ack_s;
  logic        w_active;
  logic        w_tmo_hit;
  logic [15:0] w_cnt_inc;
  logic        w_set_done;
  logic        w_set_tmo;
  logic        w_set_stuck;
  logic [31:0] w_rdata;
  logic        w_unused_wd;

  assign w_wr        = bus.chipselect & bus.write;
  assign w_ctrl_wr   = w_wr && (bus.address == 2'd0);
  assign w_stat_wr   = w_wr && (bus.address == 2'd1);
  assign w_tmo_wr    = w_wr && (bus.address == 2'd2);
  // Abort wins over start when both bits arrive in one write.
  assign w_start     = w_ctrl_wr & bus.writedata[0] & ~bus.writedata[1];
  assign w_abort     = w_ctrl_wr & bus.writedata[1];
  assign w_ack_s     = r_sync[SYNC_STAGES-1];
  assign w_active    = (r_state == ST_REQ) || (r_state == ST_REL);
  assign w_tmo_hit   = (r_tmo_val != 16'd0) && (r_count == r_tmo_val);
  assign w_cnt_inc   = (r_count == 16'hFFFF) ? r_count : r_count + 16'd1;
  assign w_set_done  = (r_state == ST_DONE);
  assign w_set_tmo   = w_active && !w_abort && w_tmo_hit;
  assign w_set_stuck = (r_state == ST_IDLE) && w_start && w_ack_s;
  assign w_unused_wd = ^bus.writedata[31:16];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.ack_in};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_req_out <= 1'b0;
      r_count   <= 16'd0;
      r_cycles  <= 16'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start && !w_ack_s) begin
            r_state   <= ST_REQ;
            r_req_out <= 1'b1;
            r_count   <= 16'd0;
          end
        end
        ST_REQ, ST_REL: begin
          r_count <= w_cnt_inc;
          if (w_abort) begin
            r_state   <= ST_IDLE;
            r_req_out <= 1'b0;
          end else if (w_tmo_hit) begin
            r_state   <= ST_IDLE;
            r_req_out <= 1'b0;
            r_cycles  <= r_count;
          end else if (r_state == ST_REQ && w_ack_s) begin
            r_state   <= ST_REL;
            r_req_out <= 1'b0;
          end else if (r_state == ST_REL && !w_ack_s) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_cycles <= r_count;
          r_state  <= ST_IDLE;
        end
        default: begin
          r_state   <= ST_IDLE;
          r_req_out <= 1'b0;
        end
      endcase
    end
  end

  // Sticky flags: a hardware set in the same cycle as a W1C clear survives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irq_en   <= 1'b0;
      r_tmo_val  <= TIMEOUT_RST;
      r_done     <= 1'b0;
      r_tmo_flag <= 1'b0;
      r_stuck    <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      if (w_ctrl_wr) r_irq_en <= bus.writedata[2];
      if (w_tmo_wr)  r_tmo_val <= bus.writedata[15:0];
      r_done     <= w_set_done  | (r_done     & ~(w_stat_wr & bus.writedata[1]));
      r_tmo_flag <= w_set_tmo   | (r_tmo_flag & ~(w_stat_wr & bus.writedata[2]));
      r_stuck    <= w_set_stuck | (r_stuck    & ~(w_stat_wr & bus.writedata[3]));
      r_irq      <= r_irq_en & (r_done | r_tmo_flag | r_stuck);
    end
  end

  always_comb begin
    w_rdata = 32'd0;
    case (bus.address)
      2'd0: w_rdata = {29'd0, r_irq_en, 2'b00};
      2'd1: w_rdata = {26'd0, r_state, r_stuck, r_tmo_flag, r_done, w_active | w_set_done};
      2'd2: w_rdata = {16'd0, r_tmo_val};
      2'd3: w_rdata = {16'd0, r_cycles};
      default: w_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata <= 32'd0;
    end else begin
      r_rdata <= w_rdata;
    end
  end

  assign bus.readdata = r_rdata;
  assign bus.req_out  = r_req_out;
  assign bus.irq      = r_irq;

endmodule

// File: tb/tb_fpga_ack_handshake_ctrl.sv
// Directed and randomized handshakes checked against closed-form cycle counts
// derived from the ack timing, synchronizer depth and TIMEOUT value.
module tb_fpga_ack_handshake_ctrl;
  localparam int S = 2;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  fpga_ack_handshake_ctrl_if bus ();

  fpga_ack_handshake_ctrl #(.TIMEOUT_RST(16'hFFFF), .SYNC_STAGES(S)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write      = 1'b1;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write      = 1'b0;
    @(negedge clk);
    d = bus.readdata;
    bus.chipselect = 1'b0;
  endtask

  // Peer raises ack d1 cycles after req_out is seen high, drops it d2 cycles after
  // req_out is seen low. rs >= 0 issues a redundant start while req_out is high.
  task automatic handshake(input int d1, input int d2, input int rs, input bit race,
                           input int tmo, input string tag);
    int hi, cf, total, cyc_exp, hi_exp;
    bit timed, ended;
    logic [31:0] rd;
    total   = d1 + d2 + 2 * S + 2;
    timed   = (tmo != 0) && (tmo < total);
    cyc_exp = timed ? tmo : total;
    hi_exp  = (timed && tmo <= d1 + S) ? tmo + 1 : d1 + S + 1;
    bus_write(2'd2, 32'(tmo));
    bus_write(2'd1, 32'hE);
    bus_write(2'd0, 32'h5);
    hi = 0; cf = -1; ended = 1'b0;
    for (int c = 0; c < 300 && !ended; c++) begin
      if (c == rs + 1) begin bus.chipselect = 1'b0; bus.write = 1'b0; end
      if (bus.req_out) hi++;
      else if (cf < 0) cf = c;
      if (c == rs && bus.req_out) begin
        bus.address = 2'd0; bus.writedata = 32'h5; bus.chipselect = 1'b1; bus.write = 1'b1;
      end
      if (c == d1) bus.ack_in = 1'b1;
      if (cf >= 0 && c == ((cf > d1) ? cf : d1) + d2) begin
        bus.ack_in = 1'b0;
        ended = 1'b1;
      end
      if (!ended) @(negedge clk);
    end
    check({tag, "_ended"}, 32'(ended), 32'd1);
    if (race) begin
      repeat (S + 1) @(negedge clk);
      bus_write(2'd1, 32'h2);
    end
    repeat (8) @(negedge clk);
    check({tag, "_req_hi"}, 32'(hi), 32'(hi_exp));
    bus_read(2'd1, rd);
    check({tag, "_status"}, rd, timed ? 32'h4 : 32'h2);
    bus_read(2'd3, rd);
    check({tag, "_cycles"}, rd, 32'(cyc_exp));
    check({tag, "_req"}, 32'(bus.req_out), 32'd0);
    check({tag, "_irq"}, 32'(bus.irq), 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    int d1, d2, tmo, rs;
    bus.address = 2'd0; bus.chipselect = 1'b0; bus.write = 1'b0;
    bus.writedata = 32'd0; bus.ack_in = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req", 32'(bus.req_out), 32'd0);
    check("rst_irq", 32'(bus.irq), 32'd0);
    check("rst_rdata", bus.readdata, 32'd0);
    reset = 1'b0;
    bus_read(2'd0, rd); check("rst_ctrl", rd, 32'd0);
    bus_read(2'd1, rd); check("rst_status", rd, 32'd0);
    bus_read(2'd2, rd); check("rst_timeout", rd, 32'hFFFF);
    bus_read(2'd3, rd); check("rst_cycles", rd, 32'd0);

    handshake(5, 3, -1, 1'b0, 32'hFFFF, "normal");
    handshake(4, 2, -1, 1'b1, 0, "race");
    bus_write(2'd1, 32'h2);
    repeat (2) @(negedge clk);
    bus_read(2'd1, rd); check("race_clr_status", rd, 32'd0);
    check("race_clr_irq", 32'(bus.irq), 32'd0);
    handshake(40, 0, -1, 1'b0, 10, "timeout");
    handshake(6, 2, 3, 1'b0, 0, "restart");

    bus_write(2'd1, 32'hE);
    bus.ack_in = 1'b1;
    repeat (S + 2) @(negedge clk);
    bus_write(2'd0, 32'h5);
    for (int k = 0; k < 4; k++) begin
      check("stuck_req", 32'(bus.req_out), 32'd0);
      @(negedge clk);
    end
    bus_read(2'd1, rd); check("stuck_status", rd, 32'h8);
    check("stuck_irq", 32'(bus.irq), 32'd1);
    bus.ack_in = 1'b0;
    repeat (S + 2) @(negedge clk);
    bus_write(2'd1, 32'h8);
    repeat (2) @(negedge clk);
    check("stuck_clr_irq", 32'(bus.irq), 32'd0);

    bus_write(2'd0, 32'h1);
    check("abort_req_on", 32'(bus.req_out), 32'd1);
    @(negedge clk);
    bus_write(2'd0, 32'h3);
    check("abort_req_off", 32'(bus.req_out), 32'd0);
    bus_read(2'd1, rd); check("abort_status", rd, 32'd0);
    bus_write(2'd0, 32'h3);
    repeat (2) @(negedge clk);
    check("conflict_req", 32'(bus.req_out), 32'd0);
    bus_read(2'd1, rd); check("conflict_status", rd, 32'd0);

    for (int i = 0; i < 24; i++) begin
      d1  = int'($urandom_range(0, 8));
      d2  = int'($urandom_range(0, 8));
      tmo = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 24));
      rs  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, d1)) : -1;
      handshake(d1, d2, rs, 1'b0, tmo, $sformatf("rnd%0d", i));
    end

    bus_write(2'd2, 32'h1234);
    bus_write(2'd0, 32'h1);
    @(negedge clk);
    check("rstmid_req_on", 32'(bus.req_out), 32'd1);
    reset = 1'b1;
    #1;
    check("rstmid_req_off", 32'(bus.req_out), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    bus_read(2'd2, rd); check("rstmid_timeout", rd, 32'hFFFF);
    bus_read(2'd1, rd); check("rstmid_status", rd, 32'd0);
    bus_read(2'd3, rd); check("rstmid_cycles", rd, 32'd0);
    bus_read(2'd0, rd); check("rstmid_ctrl", rd, 32'd0);
    check("rstmid_irq", 32'(bus.irq), 32'd0);
    repeat (4) @(negedge clk);
    check("rstmid_no_restart", 32'(bus.req_out), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
